// File: rtl/cpu31_pkg.sv
// Shared CPU31 types and constants for the fetch stage.
// Holds the fetch FSM state encoding, word width and default reset PC.
package cpu31_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] RESET_PC_DEF = 32'h0040_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Fetch program counter: reset load, +4 step and word-aligned redirect.
// Ports: clk_i, rst_i, inc_i, load_i, load_pc_i[31:0] -> pc_o[31:0].
module fetch_pc
  import cpu31_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] load_pc_i,
  output logic [INSTR_W-1:0] pc_o
);

  localparam logic [INSTR_W-1:0] ALIGN =
    {{(INSTR_W-2){1'b1}}, 2'b00};

  logic [INSTR_W-1:0] pc_q;
  logic [INSTR_W-1:0] pc_d;

  // Redirect wins over increment; increment wraps mod 2^32.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i & ALIGN;
    end else if (inc_i) begin
      pc_d = pc_q + INSTR_W'(4);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// CPU31 instruction fetch stage: one outstanding imem read, output
// register to decode, redirect squash. Optional INSTR_FETCH_MISALIGN_EN
// halts on misaligned redirect and raises sticky misalign_err.
// Ports: clk, rst, imem_req/addr/gnt/rvalid/rdata, instr_valid/code/pc,
// instr_ready, redirect_valid/pc, misalign_err.
module instr_fetch
  import cpu31_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_code,
  output logic [INSTR_W-1:0] instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               misalign_err
);

  fetch_state_t state_q, state_d;
  logic disc_q, disc_d;
  logic pc_inc, pc_ld, cap, clr;
  logic halt;
  logic [INSTR_W-1:0] pc;

  logic               valid_q;
  logic [INSTR_W-1:0] code_q;
  logic [INSTR_W-1:0] ipc_q;

`ifdef INSTR_FETCH_MISALIGN_EN
  logic mis_q, mis_d;
  logic mis_hit;

  assign mis_hit = redirect_valid &&
                   (state_q != S_IDLE) &&
                   (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign mis_d        = mis_q | mis_hit;
  assign halt         = mis_q;
  assign misalign_err = mis_q;
`else
  assign halt         = 1'b0;
  assign misalign_err = 1'b0;
`endif

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk_i     (clk),
    .rst_i     (rst),
    .inc_i     (pc_inc),
    .load_i    (pc_ld),
    .load_pc_i (redirect_pc),
    .pc_o      (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      disc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      disc_q  <= disc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    disc_d  = disc_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    cap     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_gnt) state_d = S_WAIT;
        if (redirect_valid) pc_ld = 1'b1;
        // A grant taken together with a redirect is stale.
        disc_d = redirect_valid && imem_gnt;
      end
      S_WAIT: begin
        if (redirect_valid) pc_ld = 1'b1;
        if (imem_rvalid) begin
          disc_d = 1'b0;
          if (disc_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            cap     = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          disc_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_ld   = 1'b1;
          clr     = 1'b1;
          state_d = S_REQ;
        end else if (instr_ready) begin
          clr     = 1'b1;
          state_d = S_REQ;
        end
      end
    endcase
`ifdef INSTR_FETCH_MISALIGN_EN
    // Park in idle until reset; any reply in flight is ignored there.
    if (mis_hit) begin
      state_d = S_IDLE;
      disc_d  = 1'b0;
      cap     = 1'b0;
      pc_inc  = 1'b0;
      clr     = 1'b1;
    end
`endif
  end

  always_comb begin
    imem_req = (state_q == S_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      ipc_q   <= '0;
    end else if (cap) begin
      valid_q <= 1'b1;
      code_q  <= imem_rdata;
      ipc_q   <= pc;
    end else if (clr) begin
      valid_q <= 1'b0;
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = valid_q;
  assign instr_code  = code_q;
  assign instr_pc    = ipc_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the CPU31 core, directly upstream of the instruction decoder. Holds the PC, issues one word read at a time to instruction memory over a request/grant/response handshake, and presents each fetched word with its PC to the decoder through a valid/ready output register. Branch and jump redirects from the execute stage squash any in-flight or held instruction and restart fetch at the new PC.

## Interface
- RESET_PC, 32'h0040_0000, PC of the first fetch after reset
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  read request, held until granted
- imem_addr  out  32  word address of request (PC, bits [1:0] = 0)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid (only honoured in S_WAIT)
- imem_rdata  in  32  instruction word
- instr_valid  out  1  instr_code/instr_pc hold a fetched instruction
- instr_code  out  32  instruction word to decoder
- instr_pc  out  32  PC of instr_code
- instr_ready  in  1  decoder accepts instruction this cycle
- redirect_valid  in  1  redirect fetch to redirect_pc
- redirect_pc  in  32  new PC
- misalign_err  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- FSM states: S_IDLE (reset state), S_REQ, S_WAIT, S_HOLD.
- S_IDLE -> S_REQ unconditionally on the first edge after rst deasserts.
- S_REQ: imem_req=1, imem_addr=pc. imem_gnt=1 -> S_WAIT.
- S_WAIT: imem_req=0. imem_rvalid=1 -> capture imem_rdata into instr_code, pc into instr_pc, set instr_valid, pc <= pc+4 -> S_HOLD.
- S_HOLD: instr_valid=1, outputs stable. instr_ready=1 -> clear instr_valid -> S_REQ.
- PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Redirect (any state except S_IDLE): pc <= {redirect_pc[31:2],2'b00}.
  - S_REQ: next state S_REQ; new address presented next cycle. If imem_gnt same cycle, the granted request is treated as in flight and discarded (go S_WAIT with discard set).
  - S_WAIT: set discard; response on arrival is dropped, instr_valid stays 0, -> S_REQ.
  - S_HOLD: instr_valid cleared next cycle, -> S_REQ. If instr_ready=1 the same cycle, the transfer counts as completed; the redirect still applies to the next fetch.
- redirect_valid during S_IDLE is ignored.
- Only one outstanding imem request ever.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_code=0, instr_pc=0, misalign_err=0; pc=RESET_PC, discard=0.
- rst asserts mid-operation: all state returns to reset values immediately (asynchronous); any pending response is ignored after reset.
- First imem_req: 1 cycle after rst deasserts.
- rvalid -> instr_valid: 1 cycle (registered).
- Minimum 3 cycles per instruction (REQ with gnt, WAIT with rvalid, HOLD with ready).
- Redirect -> imem_req with new address: next cycle when in S_REQ/S_HOLD; after the pending response when in S_WAIT.
- imem_addr and instr_* are registered outputs; imem_req is decoded from state.

## Configuration
- INSTR_FETCH_MISALIGN_EN defined: redirect with redirect_pc[1:0]!=0 sets misalign_err (sticky until rst), clears instr_valid and parks FSM in S_IDLE-equivalent halt (no further requests) until reset.
- Not defined: low bits silently forced to 0, fetch continues; misalign_err tied 0.

## Structure
- Shared package cpu31_pkg: fetch state enum, RESET_PC default constant, INSTR_W=32.
- One sub-module fetch_pc: PC register with reset load, +4 increment and redirect load; FSM and output register stay in instr_fetch.

## Test plan
- Reset, gnt and rvalid same-as-allowed, ready=1 always -> imem_addr 0x00400000, 0x00400004, 0x00400008; instr_valid every 3rd cycle with matching instr_pc.
- Hold instr_ready=0 for 5 cycles in S_HOLD -> instr_code/instr_pc stable, no imem_req asserted.
- Redirect to 0x00400100 while in S_WAIT, rvalid 2 cycles later with 0x2008_0005 -> word dropped, next imem_addr 0x00400100.
- Redirect in S_HOLD with instr_ready=1 same cycle -> transfer accepted once, next imem_addr = redirect target.
- Redirect to 0xFFFF_FFFC -> next fetch address 0x0000_0000 after increment.
- Redirect to 0x00400102 -> with INSTR_FETCH_MISALIGN_EN, misalign_err=1 and no further imem_req; without, imem_addr 0x00400100.
